// File: rtl/mips_stack_ctrl.sv
// Multicycle Moore control unit for the 8-bit stack CPU: fetch, decode and per-opcode
// execute sequencing, with stack-underflow detection that either halts or skips.
module mips_stack_ctrl #(
    parameter bit HALT_ON_UNDERFLOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] opcode,
    input  logic       stack_empty,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       PCsrc,
    output logic       AdSelect,
    output logic       ALUsrcB,
    output logic       IRwrite,
    output logic       push,
    output logic       pop,
    output logic       tos,
    output logic       MemRead,
    output logic       MemWrite,
    output logic [1:0] dinSel,
    output logic [1:0] ALUsrcA,
    output logic [1:0] ALUcontrol,
    output logic       halted
);

    typedef enum logic [3:0] {
        S_IF        = 4'd0,
        S_ID        = 4'd1,
        S_POP1      = 4'd2,
        S_BIN_CHK   = 4'd3,
        S_BIN_EX    = 4'd4,
        S_NOT_EX    = 4'd5,
        S_PUSH_RES  = 4'd6,
        S_MEM_RD    = 4'd7,
        S_PUSH_MEM  = 4'd8,
        S_MEM_WR    = 4'd9,
        S_JMP       = 4'd10,
        S_JZ_TOS    = 4'd11,
        S_JZ_EX     = 4'd12,
        S_UNDERFLOW = 4'd13,
        S_HALT      = 4'd14
    } state_e;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_NOT  = 3'b011;
    localparam logic [2:0] OP_PUSH = 3'b100;
    localparam logic [2:0] OP_POP  = 3'b101;
    localparam logic [2:0] OP_JMP  = 3'b110;
    localparam logic [2:0] OP_JZ   = 3'b111;

    localparam logic [1:0] ALU_ADD    = 2'd0;
    localparam logic [1:0] ALU_NOT    = 2'd3;
    localparam logic [1:0] DIN_MDR    = 2'd0;
    localparam logic [1:0] DIN_ALU    = 2'd1;
    localparam logic [1:0] SRCA_STACK = 2'd0;
    localparam logic [1:0] SRCA_ZERO  = 2'd1;
    localparam logic [1:0] SRCA_ONE   = 2'd2;

    state_e state_q;
    state_e state_d;

    // State register; reset always lands on a fresh fetch.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IF;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and Moore output decode; everything is held low while in reset.
    always_comb begin
        state_d     = S_IF;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        PCsrc       = 1'b0;
        AdSelect    = 1'b0;
        ALUsrcB     = 1'b0;
        IRwrite     = 1'b0;
        push        = 1'b0;
        pop         = 1'b0;
        tos         = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        dinSel      = DIN_MDR;
        ALUsrcA     = SRCA_STACK;
        ALUcontrol  = ALU_ADD;
        halted      = 1'b0;

        case (state_q)
            S_IF: begin
                MemRead    = 1'b1;
                IRwrite    = 1'b1;
                ALUsrcA    = SRCA_ONE;
                ALUcontrol = ALU_ADD;
                PCWrite    = 1'b1;
                state_d    = S_ID;
            end
            S_ID: begin
                // PUSH and JMP are the only opcodes that never read the stack.
                if (stack_empty && (opcode != OP_PUSH) && (opcode != OP_JMP)) begin
                    state_d = S_UNDERFLOW;
                end else begin
                    case (opcode)
                        OP_ADD, OP_SUB, OP_AND: state_d = S_POP1;
                        OP_NOT:                 state_d = S_NOT_EX;
                        OP_PUSH:                state_d = S_MEM_RD;
                        OP_POP:                 state_d = S_POP1;
                        OP_JMP:                 state_d = S_JMP;
                        OP_JZ:                  state_d = S_JZ_TOS;
                        default:                state_d = S_IF;
                    endcase
                end
            end
            S_POP1: begin
                pop     = 1'b1;
                state_d = (opcode == OP_POP) ? S_MEM_WR : S_BIN_CHK;
            end
            S_BIN_CHK: begin
                state_d = stack_empty ? S_UNDERFLOW : S_BIN_EX;
            end
            S_BIN_EX: begin
                pop        = 1'b1;
                ALUsrcA    = SRCA_STACK;
                ALUsrcB    = 1'b1;
                ALUcontrol = opcode[1:0];
                state_d    = S_PUSH_RES;
            end
            S_NOT_EX: begin
                pop        = 1'b1;
                ALUsrcA    = SRCA_STACK;
                ALUcontrol = ALU_NOT;
                state_d    = S_PUSH_RES;
            end
            S_PUSH_RES: begin
                push    = 1'b1;
                dinSel  = DIN_ALU;
                state_d = S_IF;
            end
            S_MEM_RD: begin
                AdSelect = 1'b1;
                MemRead  = 1'b1;
                state_d  = S_PUSH_MEM;
            end
            S_PUSH_MEM: begin
                push    = 1'b1;
                dinSel  = DIN_MDR;
                state_d = S_IF;
            end
            S_MEM_WR: begin
                AdSelect = 1'b1;
                MemWrite = 1'b1;
                state_d  = S_IF;
            end
            S_JMP: begin
                PCsrc   = 1'b1;
                PCWrite = 1'b1;
                state_d = S_IF;
            end
            S_JZ_TOS: begin
                tos     = 1'b1;
                state_d = S_JZ_EX;
            end
            S_JZ_EX: begin
                // ALU computes 0 + top so the datapath's zero flag gates the branch.
                ALUsrcA     = SRCA_ZERO;
                ALUsrcB     = 1'b1;
                ALUcontrol  = ALU_ADD;
                PCsrc       = 1'b1;
                PCWriteCond = 1'b1;
                state_d     = S_IF;
            end
            S_UNDERFLOW: begin
                state_d = HALT_ON_UNDERFLOW ? S_HALT : S_IF;
            end
            S_HALT: begin
                halted  = 1'b1;
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IF;
            end
        endcase

        if (!rst) begin
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            PCsrc       = 1'b0;
            AdSelect    = 1'b0;
            ALUsrcB     = 1'b0;
            IRwrite     = 1'b0;
            push        = 1'b0;
            pop         = 1'b0;
            tos         = 1'b0;
            MemRead     = 1'b0;
            MemWrite    = 1'b0;
            dinSel      = DIN_MDR;
            ALUsrcA     = SRCA_STACK;
            ALUcontrol  = ALU_ADD;
            halted      = 1'b0;
        end
    end

endmodule

// File: tb/tb_mips_stack_ctrl.sv
// Bench for mips_stack_ctrl: two instances (halt / skip on underflow) checked every cycle
// against a per-opcode cycle-table model, plus hand-computed control words.
module tb_mips_stack_ctrl;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       pc_src;
        logic       ad_select;
        logic       alu_src_b;
        logic       ir_write;
        logic       push;
        logic       pop;
        logic       tos;
        logic       mem_read;
        logic       mem_write;
        logic [1:0] din_sel;
        logic [1:0] alu_src_a;
        logic [1:0] alu_control;
        logic       halted;
    } ctl_t;

    localparam ctl_t L_ZERO     = 18'h00000;
    localparam ctl_t L_IF       = 18'h21110;
    localparam ctl_t L_MEM_RD   = 18'h04100;
    localparam ctl_t L_PUSH_MEM = 18'h00800;
    localparam ctl_t L_SUB_EX   = 18'h02402;
    localparam ctl_t L_PUSH_RES = 18'h00820;
    localparam ctl_t L_JZ_TOS   = 18'h00200;
    localparam ctl_t L_JZ_EX    = 18'h1A008;
    localparam ctl_t L_HALT     = 18'h00001;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] opcode = 3'd0;
    logic       stack_empty = 1'b0;

    logic       pcw0, pcwc0, pcs0, ads0, srcb0, irw0, psh0, pp0, tos0, mr0, mw0, hlt0;
    logic [1:0] din0, srca0, aluc0;
    logic       pcw1, pcwc1, pcs1, ads1, srcb1, irw1, psh1, pp1, tos1, mr1, mw1, hlt1;
    logic [1:0] din1, srca1, aluc1;
    ctl_t       got0, got1;

    assign got0 = {pcw0, pcwc0, pcs0, ads0, srcb0, irw0, psh0, pp0, tos0, mr0, mw0, din0, srca0, aluc0, hlt0};
    assign got1 = {pcw1, pcwc1, pcs1, ads1, srcb1, irw1, psh1, pp1, tos1, mr1, mw1, din1, srca1, aluc1, hlt1};

    mips_stack_ctrl #(.HALT_ON_UNDERFLOW(1'b0)) u_skip (
        .clk(clk), .rst(rst), .opcode(opcode), .stack_empty(stack_empty),
        .PCWrite(pcw0), .PCWriteCond(pcwc0), .PCsrc(pcs0), .AdSelect(ads0),
        .ALUsrcB(srcb0), .IRwrite(irw0), .push(psh0), .pop(pp0), .tos(tos0),
        .MemRead(mr0), .MemWrite(mw0), .dinSel(din0), .ALUsrcA(srca0),
        .ALUcontrol(aluc0), .halted(hlt0)
    );

    mips_stack_ctrl #(.HALT_ON_UNDERFLOW(1'b1)) u_halt (
        .clk(clk), .rst(rst), .opcode(opcode), .stack_empty(stack_empty),
        .PCWrite(pcw1), .PCWriteCond(pcwc1), .PCsrc(pcs1), .AdSelect(ads1),
        .ALUsrcB(srcb1), .IRwrite(irw1), .push(psh1), .pop(pp1), .tos(tos1),
        .MemRead(mr1), .MemWrite(mw1), .dinSel(din1), .ALUsrcA(srca1),
        .ALUcontrol(aluc1), .halted(hlt1)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: cycle index within the current instruction, plus underflow/halt flags.
    int         m_step [2] = '{0, 0};
    logic [2:0] m_op   [2] = '{3'd0, 3'd0};
    bit         m_uf   [2] = '{1'b0, 1'b0};
    bit         m_halt [2] = '{1'b0, 1'b0};

    function automatic int len_of(input logic [2:0] op);
        case (op)
            3'd6:                return 3;
            3'd3, 3'd4, 3'd5, 3'd7: return 4;
            default:             return 6;
        endcase
    endfunction

    function automatic bit reads_stack(input logic [2:0] op);
        return (op != 3'd4) && (op != 3'd6);
    endfunction

    task automatic model_step(input int i, input bit halt_mode);
        if (!rst) begin
            m_step[i] = 0; m_uf[i] = 1'b0; m_halt[i] = 1'b0;
        end else if (m_halt[i]) begin
            m_halt[i] = 1'b1;
        end else if (m_uf[i]) begin
            m_uf[i] = 1'b0;
            if (halt_mode) m_halt[i] = 1'b1;
            else m_step[i] = 0;
        end else if (m_step[i] == 1) begin
            m_op[i] = opcode;
            if (reads_stack(opcode) && stack_empty) m_uf[i] = 1'b1;
            else m_step[i] = 2;
        end else if (m_step[i] == 3 && m_op[i] <= 3'd2 && stack_empty) begin
            m_uf[i] = 1'b1;
        end else begin
            m_step[i] = m_step[i] + 1;
            if (m_step[i] == len_of(m_op[i])) m_step[i] = 0;
        end
    endtask

    function automatic ctl_t exp_of(input int i);
        ctl_t e;
        logic [2:0] op;
        e  = '0;
        op = m_op[i];
        if (!rst || m_uf[i]) return e;
        if (m_halt[i]) begin e.halted = 1'b1; return e; end
        if (m_step[i] == 0) begin
            e.mem_read = 1'b1; e.ir_write = 1'b1; e.alu_src_a = 2'd2; e.pc_write = 1'b1;
            return e;
        end
        if (m_step[i] == 1) return e;
        case (op)
            3'd4: if (m_step[i] == 2) begin e.ad_select = 1'b1; e.mem_read = 1'b1; end
                  else e.push = 1'b1;
            3'd5: if (m_step[i] == 2) e.pop = 1'b1;
                  else begin e.ad_select = 1'b1; e.mem_write = 1'b1; end
            3'd6: begin e.pc_src = 1'b1; e.pc_write = 1'b1; end
            3'd7: if (m_step[i] == 2) e.tos = 1'b1;
                  else begin
                      e.alu_src_a = 2'd1; e.alu_src_b = 1'b1; e.pc_src = 1'b1; e.pc_write_cond = 1'b1;
                  end
            3'd3: if (m_step[i] == 2) begin e.pop = 1'b1; e.alu_control = 2'd3; end
                  else begin e.push = 1'b1; e.din_sel = 2'd1; end
            default: case (m_step[i])
                2:       e.pop = 1'b1;
                4:       begin e.pop = 1'b1; e.alu_src_b = 1'b1; e.alu_control = op[1:0]; end
                5:       begin e.push = 1'b1; e.din_sel = 2'd1; end
                default: e = '0;
            endcase
        endcase
        return e;
    endfunction

    task automatic chk(input string name, input ctl_t got, input ctl_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%h exp=%h", name, $time, got, exp);
        end
    endtask

    // One clock: advance the model at the edge, compare both instances just after it.
    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            model_step(0, 1'b0);
            model_step(1, 1'b1);
            #1;
            chk("cycle_skip", got0, exp_of(0));
            chk("cycle_halt", got1, exp_of(1));
            #3;
        end
    endtask

    task automatic set(input logic r, input logic [2:0] op, input logic se);
        rst = r; opcode = op; stack_empty = se;
        #1;
    endtask

    logic [2:0] tbl_op [10] = '{3'd3, 3'd0, 3'd2, 3'd6, 3'd4, 3'd5, 3'd7, 3'd1, 3'd3, 3'd6};
    logic       tbl_se [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    initial begin
        tick(2);
        chk("reset_zero", got1, L_ZERO);
        set(1'b1, 3'd4, 1'b0);
        chk("first_if", got0, L_IF);

        // PUSH: IF, ID, MEM_RD, PUSH_MEM
        tick(2);
        chk("push_mem_rd", got1, L_MEM_RD);
        tick(1);
        chk("push_push_mem", got0, L_PUSH_MEM);
        tick(1);
        chk("push_back_if", got1, L_IF);

        // SUB: six cycles, result pushed from the ALU register
        set(1'b1, 3'd1, 1'b0);
        tick(4);
        chk("sub_bin_ex", got0, L_SUB_EX);
        tick(1);
        chk("sub_push_res", got1, L_PUSH_RES);
        tick(1);
        chk("sub_back_if", got0, L_IF);

        // JZ
        set(1'b1, 3'd7, 1'b0);
        tick(2);
        chk("jz_tos", got1, L_JZ_TOS);
        tick(1);
        chk("jz_ex", got0, L_JZ_EX);
        tick(1);

        // ADD with the stack emptying after the first pop
        set(1'b1, 3'd0, 1'b0);
        tick(2);
        set(1'b1, 3'd0, 1'b1);
        tick(2);
        chk("add_underflow", got1, L_ZERO);
        tick(1);
        chk("add_halt", got1, L_HALT);
        chk("add_skip_if", got0, L_IF);
        tick(10);
        chk("halt_held", got1, L_HALT);
        set(1'b0, 3'd0, 1'b0);
        chk("halt_cleared", got1, L_ZERO);
        tick(2);
        set(1'b1, 3'd5, 1'b1);
        chk("post_halt_if", got1, L_IF);

        // POP on an empty stack
        tick(2);
        chk("pop_underflow", got0, L_ZERO);
        tick(1);
        chk("pop_halt", got1, L_HALT);
        set(1'b0, 3'd1, 1'b0);
        tick(2);
        set(1'b1, 3'd1, 1'b0);

        // Reset in the middle of a SUB
        tick(3);
        set(1'b0, 3'd1, 1'b0);
        chk("mid_reset_zero", got0, L_ZERO);
        tick(1);
        set(1'b1, 3'd1, 1'b0);
        chk("mid_reset_if", got0, L_IF);
        tick(6);

        // Directed instruction stream; a resync reset follows any underflow
        for (int t = 0; t < 10; t++) begin
            set(1'b1, tbl_op[t], tbl_se[t]);
            if (tbl_se[t] && reads_stack(tbl_op[t])) begin
                tick(3);
                set(1'b0, tbl_op[t], 1'b0);
                tick(1);
            end else begin
                tick(len_of(tbl_op[t]));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_stack_ctrl.md
Name: mips_stack_ctrl

Overview:
- Multicycle Moore control unit for the 8-bit stack CPU datapath; sits directly upstream of the datapath and drives every datapath control input.
- Consumes the 3-bit opcode (IR[7:5]), the stack empty flag and the ALU zero result, the latter only through the datapath's PCWriteCond gating.
- Sequences fetch, decode and per-opcode execute states.
- Detects stack underflow and halts.

Parameters:
- HALT_ON_UNDERFLOW, 1, 1: underflow enters HALT until reset; 0: the offending instruction is skipped and the FSM returns to IF.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-low reset
- opcode  in  3  IR[7:5] from datapath
- stack_empty  in  1  stack holds zero entries
- PCWrite, PCWriteCond, PCsrc, AdSelect, ALUsrcB, IRwrite  out  1 each  datapath controls
- push, pop, tos, MemRead, MemWrite  out  1 each  stack and memory controls
- dinSel  out  2  stack din select: 0=MDR, 1=ALU reg, 2=popped reg
- ALUsrcA  out  2  ALU A select: 0=stack_out, 1=const 0, 2=const 1
- ALUcontrol  out  2  0=ADD, 1=SUB, 2=AND, 3=NOT(A)
- halted  out  1  FSM is in HALT

Behaviour:
- Opcodes: 000 ADD, 001 SUB, 010 AND, 011 NOT, 100 PUSH addr, 101 POP addr, 110 JMP addr, 111 JZ addr.
- The stack presents its top on stack_out in any cycle where pop or tos is 1.
- The popped, MDR and ALU registers load every cycle.
- Outputs are decoded from state only. Any signal not listed for a state is 0.
- Reset: with rst=0 at a rising edge, state becomes IF. While rst=0, all outputs are forced to 0 combinationally, including halted.
- IF: MemRead, IRwrite, AdSelect=0, ALUsrcA=2, ALUsrcB=0, ALUcontrol=ADD, PCsrc=0, PCWrite (PC<=PC+1). Next state: ID.
- ID: all outputs 0. Next state by opcode:
  - ADD/SUB/AND/NOT/POP/JZ with stack_empty=1: go to UNDERFLOW.
  - ADD/SUB/AND: POP1.
  - NOT: NOT_EX.
  - PUSH: MEM_RD.
  - POP: POP1.
  - JMP: JMP.
  - JZ: JZ_TOS.
- POP1: pop. Next: MEM_WR for the POP opcode; otherwise BIN_CHK.
- BIN_CHK: outputs 0. If stack_empty=1, go to UNDERFLOW; else BIN_EX.
- BIN_EX: pop, ALUsrcA=0, ALUsrcB=1, ALUcontrol = opcode[1:0]. Result is second-from-top op top. Next: PUSH_RES.
- NOT_EX: pop, ALUsrcA=0, ALUcontrol=NOT. Next: PUSH_RES.
- PUSH_RES: push, dinSel=1. Next: IF.
- MEM_RD: AdSelect=1, MemRead. Next: PUSH_MEM.
- PUSH_MEM: push, dinSel=0. Next: IF.
- MEM_WR: AdSelect=1, MemWrite. Next: IF.
- JMP: PCsrc=1, PCWrite. Next: IF.
- JZ_TOS: tos (non-destructive; the popped register captures the top). Next: JZ_EX.
- JZ_EX: ALUsrcA=1, ALUsrcB=1, ALUcontrol=ADD, PCsrc=1, PCWriteCond. The PC loads IR[4:0] iff the top is 0. Next: IF.
- UNDERFLOW: outputs 0. Next state is HALT if HALT_ON_UNDERFLOW=1, else IF. Stack and PC are untouched; the PC already points at the next instruction.
- HALT: halted=1, all other outputs 0. Stays in HALT until rst=0.
- Illegal or unreachable state encodings go to IF on the next edge.
- Cycle counts:
  - JMP: 3
  - PUSH, POP, JZ: 4
  - NOT: 4
  - ADD/SUB/AND: 6
- pop and push are never asserted in the same cycle.
- Reset mid-instruction aborts the instruction; the next fetch starts after rst returns to 1.

Test Plan:
- Reset: hold rst=0 for 2 cycles in any state -> all outputs 0; first cycle after release is IF with MemRead=IRwrite=PCWrite=1.
- PUSH: opcode=100, stack_empty=0 -> sequence IF, ID, MEM_RD (AdSelect=1, MemRead=1), PUSH_MEM (push=1, dinSel=0), IF; 4 cycles total.
- SUB: opcode=001, stack_empty=0 throughout -> pop=1 in POP1 and BIN_EX; ALUcontrol=01, ALUsrcA=0, ALUsrcB=1 in BIN_EX; push=1, dinSel=1 in PUSH_RES; next IF on cycle 7.
- ADD underflow: opcode=000, stack_empty=0 at ID, 1 at BIN_CHK -> UNDERFLOW then HALT, halted=1 held for 10 cycles; rst=0 clears halted. With HALT_ON_UNDERFLOW=0, the FSM returns to IF instead.
- JZ: opcode=111 -> JZ_TOS with tos=1, pop=0; JZ_EX with PCWriteCond=1, PCsrc=1, ALUsrcA=1, ALUsrcB=1, PCWrite=0.
- POP with empty stack: opcode=101, stack_empty=1 at ID -> UNDERFLOW; MemWrite and pop never asserted.
